// File: rtl/gfx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gfx_pkg
// Purpose  : Shared constants for the graphics ROM port scheduler: requester
//            indices, requester count and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package gfx_pkg;

   // Requester population
   localparam int NUM_REQ = 4;
   localparam int REQ_W   = 2;

   // Requester indices
   localparam logic [REQ_W-1:0] REQ_TX  = 2'd0;
   localparam logic [REQ_W-1:0] REQ_FG  = 2'd1;
   localparam logic [REQ_W-1:0] REQ_BG  = 2'd2;
   localparam logic [REQ_W-1:0] REQ_SPR = 2'd3;

   // Scheduler FSM encoding
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_WAIT  = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4
// Purpose  : Combinational four-way round-robin arbiter with a sprite
//            priority override (used during horizontal blank).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter4
   import gfx_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [REQ_W-1:0]   last,
   input  logic               prio,
   output logic [REQ_W-1:0]   grant_id,
   output logic               grant_valid
);

   // Sprite override first; otherwise the first requester after 'last' wins.
   // The scan runs from farthest to nearest so the nearest set bit is kept.
   always_comb begin
      grant_id    = '0;
      grant_valid = 1'b0;
      if (prio && req[REQ_SPR]) begin
         grant_id    = REQ_SPR;
         grant_valid = 1'b1;
      end else begin
         for (int i = NUM_REQ; i >= 1; i--) begin
            if (req[last + 2'(i)]) begin
               grant_id    = last + 2'(i);
               grant_valid = 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/gfx_rom_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gfx_rom_scheduler
// Purpose  : Shares one graphics ROM read port between the text, fg, bg and
//            sprite fetchers. Sprite wins during hblank, otherwise the port
//            is granted round-robin. Each access is bounded by a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module gfx_rom_scheduler
   import gfx_pkg::*;
#(
   parameter int ADDR_W  = 24,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 63
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       hbl,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*ADDR_W-1:0]  addr,
   output logic [NUM_REQ-1:0]         ack,
   output logic [DATA_W-1:0]          data,
   output logic [REQ_W-1:0]           grant_id,
   output logic                       busy,
   output logic                       rom_cs,
   output logic [ADDR_W-1:0]          rom_addr,
   input  logic [DATA_W-1:0]          rom_data,
   input  logic                       rom_valid,
   output logic                       timeout_err
);

   localparam int          CNT_W     = 6;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [REQ_W-1:0]     grant_id_q, grant_id_d;
   logic [REQ_W-1:0]     last_q, last_d;
   logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
   logic                 rom_cs_q, rom_cs_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 timeout_err_q, timeout_err_d;

   logic [REQ_W-1:0]     arb_grant;
   logic                 arb_valid;
   logic [ADDR_W-1:0]    addr_arr [NUM_REQ];
   logic                 wait_hit;

   // Split the flattened address bus into one word per requester
   for (genvar n = 0; n < NUM_REQ; n++) begin : g_addr_unpack
      assign addr_arr[n] = addr[n*ADDR_W +: ADDR_W];
   end

   rr_arbiter4 u_arb (
      .req         (req),
      .last        (last_q),
      .prio        (hbl),
      .grant_id    (arb_grant),
      .grant_valid (arb_valid)
   );

   // A WAIT cycle ends on data or on counter expiry; data takes precedence
   assign wait_hit = rom_valid || (cnt_q == TIMEOUT_C);

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         grant_id_q    <= '0;
         last_q        <= REQ_SPR;
         rom_addr_q    <= '0;
         rom_cs_q      <= 1'b0;
         ack_q         <= '0;
         data_q        <= '0;
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_id_q    <= grant_id_d;
         last_q        <= last_d;
         rom_addr_q    <= rom_addr_d;
         rom_cs_q      <= rom_cs_d;
         ack_q         <= ack_d;
         data_q        <= data_d;
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (arb_valid) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (wait_hit) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Registered output updates; ack defaults low so it pulses for one cycle
   always_comb begin
      grant_id_d    = grant_id_q;
      last_d        = last_q;
      rom_addr_d    = rom_addr_q;
      rom_cs_d      = rom_cs_q;
      ack_d         = '0;
      data_d        = data_q;
      cnt_d         = cnt_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               grant_id_d = arb_grant;
               rom_addr_d = addr_arr[arb_grant];
            end
         end
         ST_ISSUE: begin
            rom_cs_d = 1'b1;
            cnt_d    = '0;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 6'd1;
            if (wait_hit) begin
               rom_cs_d = 1'b0;
               ack_d    = ONE_HOT0 << grant_id_q;
               last_d   = grant_id_q;
               if (rom_valid) begin
                  data_d = rom_data;
               end else begin
                  data_d        = '0;
                  timeout_err_d = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Port drive; busy covers the cycles the ROM port is committed
   always_comb begin
      busy = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   end

   assign ack         = ack_q;
   assign data        = data_q;
   assign grant_id    = grant_id_q;
   assign rom_cs      = rom_cs_q;
   assign rom_addr    = rom_addr_q;
   assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_gfx_rom_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gfx_rom_scheduler
// Purpose  : Scoreboard bench for gfx_rom_scheduler with a simple ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gfx_rom_scheduler;

   localparam int ADDR_W  = 24;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 63;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 hbl;
   logic [3:0]           req;
   logic [4*ADDR_W-1:0]  addr;
   logic [3:0]           ack;
   logic [DATA_W-1:0]    data;
   logic [1:0]           grant_id;
   logic                 busy;
   logic                 rom_cs;
   logic [ADDR_W-1:0]    rom_addr;
   logic [DATA_W-1:0]    rom_data;
   logic                 rom_valid;
   logic                 timeout_err;

   typedef struct {
      logic [1:0]        id;
      logic [DATA_W-1:0] dat;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   // ROM model controls
   int                rom_lat     = 1000;
   bit                fixed_en    = 1'b0;
   logic [DATA_W-1:0] fixed_word  = '0;
   bit                force_valid = 1'b0;
   int                cs_age      = 0;

   always #5 clk = ~clk;

   gfx_rom_scheduler #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .hbl         (hbl),
      .req         (req),
      .addr        (addr),
      .ack         (ack),
      .data        (data),
      .grant_id    (grant_id),
      .busy        (busy),
      .rom_cs      (rom_cs),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .rom_valid   (rom_valid),
      .timeout_err (timeout_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
      return {8'hA0, a};
   endfunction

   task automatic push_exp(input logic [1:0] id, input logic [DATA_W-1:0] d);
      exp_t e;
      e.id  = id;
      e.dat = d;
      sb_q.push_back(e);
   endtask

   // ROM model: answers rom_lat cycles after rom_cs rises, or a forced stale strobe
   initial begin
      rom_valid = 1'b0;
      rom_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         rom_valid = 1'b0;
         if (force_valid) begin
            rom_valid   = 1'b1;
            rom_data    = 32'hBAD0BAD0;
            force_valid = 1'b0;
         end else if (rom_cs) begin
            cs_age++;
            if (cs_age == rom_lat + 1) begin
               rom_valid = 1'b1;
               rom_data  = fixed_en ? fixed_word : rom_word(rom_addr);
            end
         end else begin
            cs_age = 0;
         end
      end
   end

   // Scoreboard: every ack is checked against the oldest expectation
   always @(negedge clk) begin
      if (!reset && ack !== 4'b0000) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_ack", {60'd0, ack}, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("ack", {60'd0, ack}, {60'd0, 4'b0001 << e.id});
            chk("data", {32'd0, data}, {32'd0, e.dat});
            chk("grant_id", {62'd0, grant_id}, {62'd0, e.id});
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Returns at the negedge where ack is seen; bounded
   task automatic wait_ack();
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (ack !== 4'b0000) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("ack_wait_expired", 64'd0, 64'd1);
   endtask

   task automatic wait_cs();
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rom_cs === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("cs_wait_expired", 64'd0, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1;
      hbl   = 1'b0;
      req   = 4'b0000;
      addr  = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset values
      @(negedge clk);
      chk("rst_ack", {60'd0, ack}, 64'd0);
      chk("rst_data", {32'd0, data}, 64'd0);
      chk("rst_grant", {62'd0, grant_id}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_cs", {63'd0, rom_cs}, 64'd0);
      chk("rst_addr", {40'd0, rom_addr}, 64'd0);
      chk("rst_terr", {63'd0, timeout_err}, 64'd0);

      // Single request, ROM answers 3 cycles after rom_cs rises
      addr[0*ADDR_W +: ADDR_W] = 24'h000100;
      fixed_en   = 1'b1;
      fixed_word = 32'hDEADBEEF;
      rom_lat    = 3;
      push_exp(2'd0, 32'hDEADBEEF);
      @(posedge clk);
      #1 req = 4'b0001;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1 n++;
         if (rom_cs === 1'b1) break;
      end
      chk("cs_latency", 64'(n), 64'd2);
      chk("single_rom_addr", {40'd0, rom_addr}, 64'h100);
      chk("single_busy", {63'd0, busy}, 64'd1);
      wait_ack();
      @(posedge clk);
      #1 req = 4'b0000;
      @(negedge clk);
      chk("ack_one_cycle", {60'd0, ack}, 64'd0);

      // Round robin from reset: 0,1,2,3,0
      do_reset();
      fixed_en = 1'b0;
      rom_lat  = 2;
      for (int k = 0; k < 4; k++) addr[k*ADDR_W +: ADDR_W] = 24'(24'h100000 * k + 24'h40);
      for (int k = 0; k < 5; k++) push_exp(2'(k % 4), rom_word(24'(24'h100000 * (k % 4) + 24'h40)));
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ack();
      end
      @(posedge clk);
      #1 req = 4'b0000;

      // Hblank: four sprite grants, then round robin resumes at 0
      for (int k = 0; k < 4; k++) push_exp(2'd3, rom_word(24'h300040));
      push_exp(2'd0, rom_word(24'h000040));
      hbl = 1'b1;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ack();
         @(posedge clk);
         #1;
         if (k == 3) hbl = 1'b0;
         if (k == 4) req = 4'b0000;
      end

      // Timeout on requester 2, then a normal access
      rom_lat = 1000;
      push_exp(2'd2, 32'd0);
      req = 4'b0100;
      wait_cs();
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n++;
         if (ack !== 4'b0000) break;
      end
      chk("timeout_cycles", 64'(n), 64'(TIMEOUT + 1));
      @(posedge clk);
      #1 req = 4'b0000;
      @(negedge clk);
      chk("terr_set", {63'd0, timeout_err}, 64'd1);
      rom_lat = 1;
      push_exp(2'd2, rom_word(24'h200040));
      @(posedge clk);
      #1 req = 4'b0100;
      wait_ack();
      @(posedge clk);
      #1 req = 4'b0000;
      @(negedge clk);
      chk("terr_sticky", {63'd0, timeout_err}, 64'd1);

      // Reset during WAIT aborts without ack; stale rom_valid ignored
      rom_lat = 1000;
      @(posedge clk);
      #1 req = 4'b0001;
      wait_cs();
      repeat (3) @(negedge clk);
      chk("abort_busy_wait", {63'd0, busy}, 64'd1);
      @(posedge clk);
      #1 begin
         reset = 1'b1;
         req   = 4'b0000;
      end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_cs", {63'd0, rom_cs}, 64'd0);
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_terr_cleared", {63'd0, timeout_err}, 64'd0);
      force_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("stale_busy", {63'd0, busy}, 64'd0);
      chk("stale_cs", {63'd0, rom_cs}, 64'd0);
      rom_lat = 2;
      push_exp(2'd1, rom_word(24'h100040));
      @(posedge clk);
      #1 req = 4'b0010;
      wait_ack();
      @(posedge clk);
      #1 req = 4'b0000;

      // rom_valid on the same cycle the counter reaches TIMEOUT
      rom_lat    = TIMEOUT;
      fixed_en   = 1'b1;
      fixed_word = 32'h12345678;
      push_exp(2'd3, 32'h12345678);
      @(posedge clk);
      #1 req = 4'b1000;
      wait_ack();
      @(posedge clk);
      #1 req = 4'b0000;
      @(negedge clk);
      chk("coincident_terr", {63'd0, timeout_err}, 64'd0);

      repeat (5) @(negedge clk);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
